// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and default constants for the memory controller.
//   state_e      - controller FSM states
//   DEF_*        - default bus widths and wait-cycle counts
//   max_u        - helper used to size the wait counter
package mem_ctrl_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_RD_WAIT = 8;
  localparam int unsigned DEF_WR_WAIT = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RESP       = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with a registered zero flag.
//   clk_i, rst_i  - clock, async active-high reset
//   load_i        - load load_val_i (takes priority over decrement)
//   load_val_i    - value to load
//   dec_i         - decrement by one; saturates at zero
//   zero_o        - count is zero
module wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic             zero_q;

  // Zero flag is tracked alongside the count so it stays a register output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else if (load_i) begin
      count_q <= load_val_i;
      zero_q  <= (load_val_i == '0);
    end else if (dec_i && !zero_q) begin
      count_q <= count_q - WIDTH'(1);
      zero_q  <= (count_q == WIDTH'(1));
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mem_controller.sv
// mem_controller: single-outstanding host-to-SRAM bridge with fixed wait states.
//   clk_i, rst_i                         - clock, async active-high reset
//   req_valid_i/req_ready_o              - host request handshake
//   req_we_i, req_addr_i, req_wdata_i    - request kind, address, write data
//   rsp_valid_o/rsp_ready_i              - host response handshake
//   rsp_we_o, rsp_rdata_o                - write-ack flag, read data (0 for writes)
//   mem_wr_o, mem_addr_o, mem_data_o     - memory strobe, address, write data
//   mem_data_i                           - memory read data
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_DATA_WIDTH = DEF_DATA_W,
  parameter int unsigned RAM_ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned RD_WAIT_CYCLES = DEF_RD_WAIT,
  parameter int unsigned WR_WAIT_CYCLES = DEF_WR_WAIT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [RAM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_we_o,
  output logic [RAM_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      mem_wr_o,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] mem_data_o,
  input  logic [RAM_DATA_WIDTH-1:0] mem_data_i
);

  localparam int unsigned CNT_W = $clog2(max_u(RD_WAIT_CYCLES, WR_WAIT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT_CYCLES - 1);

  state_e                    state_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      rsp_we_q;
  logic [RAM_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      mem_wr_q;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [RAM_DATA_WIDTH-1:0] mem_data_q;

  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_d;

  // req_ready_q is 1 exactly in IDLE, so this is the accept handshake.
  assign accept     = req_ready_q && req_valid_i;
  assign cnt_load_d = req_we_i ? WR_LOAD : RD_LOAD;
  assign cnt_dec    = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);

  wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (cnt_load_d),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Controller FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mem_addr_q  <= req_addr_i;
            mem_data_q  <= req_wdata_i;
            rsp_we_q    <= req_we_i;
            mem_wr_q    <= req_we_i;
            req_ready_q <= 1'b0;
            state_q     <= req_we_i ? WRITE_WAIT : READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (cnt_zero) begin
            rsp_rdata_q <= mem_data_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WRITE_WAIT: begin
          if (cnt_zero) begin
            rsp_rdata_q <= '0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: randomized self-checking bench for mem_controller.
// u_dut uses the default wait counts against a behavioural memory;
// u_dut_min uses RD_WAIT_CYCLES = 1 for back-to-back minimum-latency reads.
module tb_mem_controller;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 10;
  localparam int unsigned RDW = 8;
  localparam int unsigned WRW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance signals
  logic          req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_we0, mem_wr0;
  logic [AW-1:0] req_addr0, mem_addr0;
  logic [DW-1:0] req_wdata0, rsp_rdata0, mem_data0, mem_rdata0;

  // Minimum-wait instance signals
  logic          req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_we1, mem_wr1;
  logic [AW-1:0] req_addr1, mem_addr1;
  logic [DW-1:0] req_wdata1, rsp_rdata1, mem_data1, mem_rdata1;

  mem_controller u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_we_o(rsp_we0),
    .rsp_rdata_o(rsp_rdata0),
    .mem_wr_o(mem_wr0), .mem_addr_o(mem_addr0), .mem_data_o(mem_data0),
    .mem_data_i(mem_rdata0)
  );

  mem_controller #(.RD_WAIT_CYCLES(1)) u_dut_min (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
    .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_we_o(rsp_we1),
    .rsp_rdata_o(rsp_rdata1),
    .mem_wr_o(mem_wr1), .mem_addr_o(mem_addr1), .mem_data_o(mem_data1),
    .mem_data_i(mem_rdata1)
  );

  // Behavioural SRAM seen by u_dut: writes land on each strobed edge.
  logic [DW-1:0] bmem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_wr0) bmem[mem_addr0] <= mem_data0;
  assign mem_rdata0 = bmem[mem_addr0];

  // Fixed address-derived pattern for the minimum-wait instance.
  assign mem_rdata1 = DW'(mem_addr1) ^ 16'h5A5A;

  // Transaction-level model: contents of completed writes.
  logic [DW-1:0] ref_mem [int];
  int            written_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete host transaction on u_dut with optional busy pulse and backpressure.
  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int bp, input logic busy);
    int            n;
    int            wr_cyc;
    logic          stable;
    logic          hold;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] rd;
    @(negedge clk);
    check_eq("ready_in_idle", 32'(req_ready0), 32'd1);
    req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = data;
    rsp_ready0 = 1'($urandom);
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_addr0 = AW'($urandom); req_wdata0 = DW'($urandom);
    check_eq("accept_addr", 32'(mem_addr0), 32'(addr));
    check_eq("accept_data", 32'(mem_data0), 32'(data));
    check_eq("busy_not_ready", 32'(req_ready0), 32'd0);
    n = 0; wr_cyc = 0; stable = 1'b1;
    while (!rsp_valid0 && n < 100) begin
      if (mem_wr0) wr_cyc++;
      if (mem_addr0 !== addr || mem_data0 !== data) stable = 1'b0;
      if (busy && n == 2) begin
        req_valid0 = 1'b1; req_addr0 = 10'h3FF; req_we0 = ~we;
      end
      if (n == 3) req_valid0 = 1'b0;
      rsp_ready0 = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    check_eq(we ? "wr_latency" : "rd_latency", 32'(n), we ? 32'(WRW) : 32'(RDW));
    check_eq("wr_strobe_cycles", 32'(wr_cyc), we ? 32'(WRW) : 32'd0);
    check_eq("mem_bus_stable", 32'(stable), 32'd1);
    check_eq("strobe_off_in_resp", 32'(mem_wr0), 32'd0);
    exp_rd = we ? '0 : ref_mem[int'(addr)];
    if (we) begin
      if (!ref_mem.exists(int'(addr))) written_q.push_back(int'(addr));
      ref_mem[int'(addr)] = data;
    end
    check_eq("rsp_we", 32'(rsp_we0), 32'(we));
    check_eq("rsp_rdata", 32'(rsp_rdata0), 32'(exp_rd));
    check_eq("resp_not_ready", 32'(req_ready0), 32'd0);
    rd = rsp_rdata0; hold = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== rd || rsp_we0 !== we || req_ready0 !== 1'b0)
        hold = 1'b0;
    end
    check_eq("backpressure_hold", 32'(hold), 32'd1);
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid0), 32'd0);
    check_eq("ready_after_rsp", 32'(req_ready0), 32'd1);
    check_eq("addr_held_idle", 32'(mem_addr0), 32'(addr));
  endtask

  initial begin
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          quiet;

    rst = 1'b1;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 1'b1;
    #1;
    check_eq("rst_ready", 32'(req_ready0), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr0), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed write then read-back of 0xBEEF at 0x05 (read has busy pulse and 5-cycle stall).
    do_txn(1'b1, 10'h005, 16'hBEEF, 0, 1'b0);
    do_txn(1'b0, 10'h005, 16'h0000, 5, 1'b1);

    // Randomized traffic; reads only target previously written addresses.
    repeat (20) begin
      we = 1'($urandom);
      if (written_q.size() == 0) we = 1'b1;
      data = DW'($urandom);
      if (we) addr = AW'($urandom);
      else addr = AW'(written_q[$urandom_range(0, written_q.size() - 1)]);
      do_txn(we, addr, data, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset during the third WRITE_WAIT cycle aborts the access.
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 10'h055; req_wdata0 = 16'h1234;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_strobe_before", 32'(mem_wr0), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_strobe_drop", 32'(mem_wr0), 32'd0);
    check_eq("abort_no_rsp", 32'(rsp_valid0), 32'd0);
    check_eq("abort_ready", 32'(req_ready0), 32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid0 !== 1'b0 || mem_wr0 !== 1'b0) quiet = 1'b0;
    end
    check_eq("abort_quiet", 32'(quiet), 32'd1);
    check_eq("abort_ready_after", 32'(req_ready0), 32'd1);

    // Minimum-wait instance: back-to-back reads of 0x000 and 0x3FF, rsp_ready held 1.
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 10'h000;
    @(posedge clk); #1;
    check_eq("min_addr0", 32'(mem_addr1), 32'h000);
    check_eq("min_busy0", 32'(rsp_valid1), 32'd0);
    req_addr1 = 10'h3FF;
    @(posedge clk); #1;
    check_eq("min_rsp0", 32'(rsp_valid1), 32'd1);
    check_eq("min_rdata0", 32'(rsp_rdata1), 32'h5A5A);
    @(posedge clk); #1;
    check_eq("min_gap_valid", 32'(rsp_valid1), 32'd0);
    check_eq("min_gap_ready", 32'(req_ready1), 32'd1);
    check_eq("min_gap_addr", 32'(mem_addr1), 32'h000);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check_eq("min_addr1", 32'(mem_addr1), 32'h3FF);
    check_eq("min_busy1", 32'(req_ready1), 32'd0);
    @(posedge clk); #1;
    check_eq("min_rsp1", 32'(rsp_valid1), 32'd1);
    check_eq("min_rdata1", 32'(rsp_rdata1), 32'h3FF ^ 32'h5A5A);
    check_eq("min_rsp_we1", 32'(rsp_we1), 32'd0);
    @(posedge clk); #1;
    check_eq("min_done_ready", 32'(req_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameter RAM_DATA_WIDTH, default 16: data width of the host and memory buses.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 10: address width of the host and memory buses.
REQ-003 SHALL have parameter RD_WAIT_CYCLES, default 8: cycles the read address is held before data is sampled; legal range >= 1.
REQ-004 SHALL have parameter WR_WAIT_CYCLES, default 16: cycles the write strobe, address and data are held; legal range >= 1.
REQ-005 SHALL use one clock and an asynchronous, active-high reset (port list: name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  controller accepts a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  RAM_ADDR_WIDTH  request address.
- req_wdata_i  in  RAM_DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host accepts the response.
- rsp_we_o  out  1  response is a write acknowledge.
- rsp_rdata_o  out  RAM_DATA_WIDTH  read data; 0 for writes.
- mem_wr_o  out  1  memory write strobe.
- mem_addr_o  out  RAM_ADDR_WIDTH  memory address.
- mem_data_o  out  RAM_DATA_WIDTH  memory write data.
- mem_data_i  in  RAM_DATA_WIDTH  memory read data.

Function
REQ-006 SHALL implement an FSM with four states: IDLE, READ_WAIT, WRITE_WAIT and RESP.
REQ-007 SHALL assert req_ready_o only in IDLE; a request is accepted on the edge where req_valid_i and req_ready_o are both 1.
REQ-008 SHALL, on acceptance, perform all of the following on that edge:
- register req_addr_i into mem_addr_o, req_wdata_i into mem_data_o and req_we_i into rsp_we_o;
- load the wait counter with WAIT-1, where WAIT is WR_WAIT_CYCLES for a write and RD_WAIT_CYCLES for a read;
- go to WRITE_WAIT for a write or READ_WAIT for a read.
REQ-009 SHALL hold mem_addr_o and mem_data_o stable from acceptance until the next acceptance, including through RESP and IDLE.
REQ-010 SHALL drive mem_wr_o = 1 exactly while in WRITE_WAIT and 0 in every other state.
REQ-011 SHALL decrement the counter on each edge in a WAIT state; on the edge where the counter is 0, the FSM SHALL go to RESP, so each WAIT state lasts exactly WAIT cycles.
REQ-012 SHALL, on the READ_WAIT to RESP edge, register mem_data_i into rsp_rdata_o; on the WRITE_WAIT to RESP edge, rsp_rdata_o SHALL be set to 0.
REQ-013 SHALL assert rsp_valid_o only in RESP, with rsp_we_o and rsp_rdata_o stable while rsp_valid_o is 1 and rsp_ready_i is 0.
REQ-014 SHALL go from RESP to IDLE on the edge where rsp_valid_o and rsp_ready_i are both 1; the earliest next acceptance is one cycle later.
REQ-015 SHALL give a request-accept to rsp_valid_o latency of exactly WAIT cycles when rsp_ready_i is held at 1.
REQ-016 SHALL ignore req_valid_i and all request fields outside IDLE; no request is queued.
REQ-017 SHALL size the counter as $clog2(max(RD_WAIT_CYCLES, WR_WAIT_CYCLES)+1) bits, unsigned; it SHALL never wrap below 0.
REQ-018 SHALL treat rsp_ready_i asserted outside RESP as a no-op.

Reset
REQ-019 SHALL, while rst_i = 1, immediately and asynchronously set: state IDLE, counter 0, mem_wr_o 0, mem_addr_o 0, mem_data_o 0, rsp_valid_o 0, rsp_we_o 0, rsp_rdata_o 0; req_ready_o follows as 1.
REQ-020 SHALL abort any in-flight access when rst_i is asserted mid-operation (mem_wr_o drops without waiting for a clock) and SHALL NOT generate a response for the aborted access.
REQ-021 SHALL accept its first request no earlier than the first clock edge after rst_i deasserts.

Structure
REQ-022 SHALL import a shared package mem_ctrl_pkg holding the state enum type and the default width and wait-cycle constants.
REQ-023 SHALL instantiate one sub-module, wait_counter (loadable down-counter with a zero flag), parameterised by width.
REQ-024 SHALL be fully synchronous to clk_i apart from the reset, with no latches and no delay constructs.

Verification
REQ-025 SHALL pass a write test: with WR_WAIT_CYCLES = 16, write addr 0x05, data 0xBEEF -> mem_wr_o is high exactly 16 cycles with mem_addr_o = 0x05 and mem_data_o = 0xBEEF, then rsp_valid_o = 1, rsp_we_o = 1, rsp_rdata_o = 0.
REQ-026 SHALL pass a read-back test: with a behavioural memory returning 0xBEEF at 0x05 and RD_WAIT_CYCLES = 8, read 0x05 -> rsp_valid_o rises exactly 8 cycles after acceptance with rsp_rdata_o = 0xBEEF and rsp_we_o = 0.
REQ-027 SHALL pass a backpressure test: rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o and rsp_rdata_o hold; req_ready_o stays 0 throughout.
REQ-028 SHALL pass a busy-request test: req_valid_i pulsed with addr 0x3FF during READ_WAIT -> the request is ignored and mem_addr_o is unchanged.
REQ-029 SHALL pass a reset-abort test: rst_i asserted at cycle 3 of WRITE_WAIT -> mem_wr_o drops to 0 immediately, no rsp_valid_o, and req_ready_o = 1 after release.
REQ-030 SHALL pass a minimum-wait test: RD_WAIT_CYCLES = 1 with back-to-back reads of 0x000 and 0x3FF -> each response arrives 1 cycle after acceptance, addresses are correct, and a 1-cycle IDLE gap separates the two.
